clk_div_bank: RTL

CLK_DIV_BANK -- requirements
Module: clk_div_bank

---
 rtl/clk_div_bank_if.sv | 27 ++
 rtl/clk_div_bank.sv | 102 ++++++++++
 2 files changed

// File: rtl/clk_div_bank_if.sv
// Configuration, control and status bundle for clk_div_bank.
// The master side (bench or host) drives cfg/run/sync; the slave (divider bank) drives the status.
interface clk_div_bank_if #(
  parameter int unsigned NCH   = 2,
  parameter int unsigned DIV_W = 8,
  parameter int unsigned CH_W  = 1
);
  logic             cfg_we;
  logic [CH_W-1:0]  cfg_ch;
  logic [DIV_W-1:0] cfg_div;
  logic [NCH-1:0]   run;
  logic             sync;
  logic [NCH-1:0]   clk_out;
  logic [NCH-1:0]   tick;
  logic [NCH-1:0]   rise;
  logic [NCH-1:0]   busy;

  modport master (
    output cfg_we, cfg_ch, cfg_div, run, sync,
    input  clk_out, tick, rise, busy
  );

  modport slave (
    input  cfg_we, cfg_ch, cfg_div, run, sync,
    output clk_out, tick, rise, busy
  );
endinterface

// File: rtl/clk_div_bank.sv
// Bank of independent programmable clock dividers with glitch-free retuning,
// clean stop/start and a shared phase-align strobe.
module clk_div_bank #(
  parameter int unsigned NCH     = 2,
  parameter int unsigned DIV_W   = 8,
  parameter int unsigned DEF_DIV = 15,
  parameter int unsigned CH_W    = 1
) (
  input  logic          sysclk,
  input  logic          reset,
  clk_div_bank_if.slave bus
);

  typedef logic [DIV_W-1:0] div_t;

  div_t           count_q    [NCH];
  div_t           count_d    [NCH];
  div_t           div_q      [NCH];
  div_t           div_d      [NCH];
  div_t           pend_div_q [NCH];
  div_t           pend_div_d [NCH];
  logic [NCH-1:0] pend_q, pend_d;
  logic [NCH-1:0] clk_q, clk_d;
  logic [NCH-1:0] tick_q, tick_d;
  logic [NCH-1:0] rise_q, rise_d;
  logic [NCH-1:0] apply;

  always_comb begin
    for (int unsigned i = 0; i < NCH; i++) begin
      count_d[i]    = count_q[i];
      div_d[i]      = div_q[i];
      pend_div_d[i] = pend_div_q[i];
      pend_d[i]     = pend_q[i];
      clk_d[i]      = clk_q[i];
      tick_d[i]     = 1'b0;
      rise_d[i]     = 1'b0;
      apply[i]      = 1'b0;

      if (bus.sync) begin
        count_d[i] = '0;
        clk_d[i]   = 1'b0;
        apply[i]   = pend_q[i];
      end else if (bus.run[i] || clk_q[i]) begin
        // A high phase always runs to completion, so dropping run never cuts a pulse short.
        if (count_q[i] == div_q[i]) begin
          count_d[i] = '0;
          clk_d[i]   = ~clk_q[i];
          tick_d[i]  = 1'b1;
          rise_d[i]  = ~clk_q[i];
          // Retune only at the falling edge so each full period uses one divisor.
          apply[i]   = pend_q[i] & clk_q[i];
        end else begin
          count_d[i] = count_q[i] + div_t'(1);
        end
      end else begin
        count_d[i] = '0;
        apply[i]   = pend_q[i];
      end

      if (apply[i]) begin
        div_d[i]  = pend_div_q[i];
        pend_d[i] = 1'b0;
      end

      // A write landing on the apply edge wins: it re-arms pend with the new value.
      if (bus.cfg_we && (32'(bus.cfg_ch) == i)) begin
        pend_div_d[i] = bus.cfg_div;
        pend_d[i]     = 1'b1;
      end
    end
  end

  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < NCH; i++) begin
        count_q[i]    <= '0;
        div_q[i]      <= div_t'(DEF_DIV);
        pend_div_q[i] <= div_t'(DEF_DIV);
      end
      pend_q <= '0;
      clk_q  <= '0;
      tick_q <= '0;
      rise_q <= '0;
    end else begin
      for (int unsigned i = 0; i < NCH; i++) begin
        count_q[i]    <= count_d[i];
        div_q[i]      <= div_d[i];
        pend_div_q[i] <= pend_div_d[i];
      end
      pend_q <= pend_d;
      clk_q  <= clk_d;
      tick_q <= tick_d;
      rise_q <= rise_d;
    end
  end

  assign bus.clk_out = clk_q;
  assign bus.tick    = tick_q;
  assign bus.rise    = rise_q;
  assign bus.busy    = pend_q;

endmodule
